alu_la_self_test: RTL and testbench
===================================

# alu_la_self_test

Self-checking 4-bit arithmetic unit subsystem. Contains three parts: a stimulus generator, a registered 4-bit arithmetic unit built on a carry-lookahead adder, and a result analyzer. The generator sweeps operand/function vectors. The arithmetic unit computes results with registered inputs and outputs. The analyzer compares each result against a golden model aligned to the unit's latency and counts mismatches. It sits in the datapath bring-up area as a built-in self-test for the lookahead ALU.

## Interface
Parameters:
- A_INIT, 4'b0100, operand a loaded at reset
- B_INIT, 4'b0010, operand b loaded at reset

Ports:
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- fault_inj  in  1  travels with the current vector; when set, inverts bit 0 of that vector's sum
- a  out  4  current generator operand A
- b  out  4  current generator operand B
- sel  out  3  current function select {s0,s1,cin}; s0 is the MSB
- d  out  4  registered ALU result
- cout  out  1  registered ALU carry-out
- exp_d  out  4  golden result, aligned with d
- exp_cout  out  1  golden carry, aligned with cout
- chk_valid  out  1  d/cout hold a checkable result
- err  out  1  registered one-cycle mismatch flag
- err_cnt  out  16  mismatch count, saturating at 16'hFFFF

## Operation
- **Generator:** holds an 11-bit state {b,a,sel}.
  - Reset loads {B_INIT, A_INIT, 3'b000}.
  - Every non-reset edge increments the state by 1; it wraps 2^11 → 0.
  - a, b and sel are driven directly from this state.
- **ALU input register:** captures a, b, ~b, s0, s1, cin and fault_inj on every edge.
- **Operand mux:** Y = B when {s0,s1}=00; ~B when 01; 4'b0000 when 10; 4'b1111 when 11.
- **Adder:** {COUT,D} = A + Y + cin.
  - P[i] = A[i]^Y[i], G[i] = A[i]&Y[i].
  - c[i+1] = G[i] | P[i]&c[i], c0 = cin.
  - Sum bit S[i] = P[i]^c[i]; cout = c4.
  - Carries come from P/G lookahead logic, not a ripple chain of full adders.
- **Fault injection:** if the registered fault_inj is set, D[0] is inverted before the output register.
- **Function table** (sel → result):
  - 000: A+B
  - 001: A+B+1
  - 010: A+~B
  - 011: A−B
  - 100: A
  - 101: A+1
  - 110: A−1
  - 111: A (carry set)
- **ALU output register:** captures {COUT,D} into {cout,d}.
- **Golden model:** computes {c,r} = a + Y(a,b,sel) + cin (5-bit) from the generator outputs, then delays it through 2 stages to form exp_cout/exp_d.
- **Valid tracking:** a 2-bit valid shift register, cleared by reset and shifted with 1; chk_valid = stage 2.
- **Analyzer:** each edge, err <= chk_valid & ({cout,d} != {exp_cout,exp_d}); err_cnt increments on the same condition and saturates.
- **Reset values:**
  - d, cout, exp_d, exp_cout = 0
  - err, err_cnt, chk_valid, all pipeline registers = 0
  - generator state as above
- No # delays; fully synthesizable.

## Timing
- Cycle 0 is the first cycle with RST low; the generator presents vector G(t) during cycle t.
- G(t) is captured into the input register at the end of cycle t.
- {cout,d} for G(t) is valid during cycle t+2 (latency 2), and exp_* is aligned with it.
- err/err_cnt reflect G(t) during cycle t+3.
- fault_inj asserted in cycle k corrupts G(k): d[0] is wrong in cycle k+2, err=1 in cycle k+3.
- Reset mid-run clears all pipelines and valid, so no err is raised for 3 cycles afterwards.
- Simultaneous RST and mismatch: reset wins; err_cnt becomes 0.
- err_cnt at FFFF stays at FFFF.

## Test plan
- **Reset:** RST=1 for 2 cycles → a=0100, b=0010, sel=000; d=0, cout=0, err=0, err_cnt=0, chk_valid=0.
- **First result:** release reset → cycle 2 gives chk_valid=1, d=0110, cout=0, exp matches, err stays 0.
- **Sel sweep:** a=0100, b=0010, sel 000..111 → {cout,d} sequence:
  - 0_0110, 0_0111, 1_0001, 1_0010
  - 0_0100, 0_0101, 1_0011, 1_0100
  - each result appears 2 cycles after its sel.
- **Fault detection:** fault_inj=1 in cycle 5 only → d[0] flipped in cycle 7; err=1 in cycle 8 only; err_cnt=1.
- **Exhaustive sweep:** run 2051 cycles with fault_inj=0 → err never set, err_cnt=0; generator back to a=0100, b=0010, sel=000 at cycle 2048.
- **Reset mid-run:** assert RST after an injected error → err_cnt=0, chk_valid=0, no err in the 3 cycles following release.

Source files
------------

// File: rtl/alu_la_self_test.sv
// Built-in self-test for a registered 4-bit carry-lookahead ALU: a counting
// vector generator feeds the ALU and a latency-aligned golden model, and the analyzer counts disagreements.
module alu_la_self_test #(
    parameter logic [3:0] A_INIT = 4'b0100,
    parameter logic [3:0] B_INIT = 4'b0010
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        fault_inj,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic [2:0]  sel,
    output logic [3:0]  d,
    output logic        cout,
    output logic [3:0]  exp_d,
    output logic        exp_cout,
    output logic        chk_valid,
    output logic        err,
    output logic [15:0] err_cnt
);

    localparam logic [10:0] GEN_RST = {B_INIT, A_INIT, 3'b000};

    // generator state {b, a, sel}
    logic [10:0] gen_q, gen_d;

    // ALU input register
    logic [3:0]  in_a_q, in_a_d;
    logic [3:0]  in_b_q, in_b_d;
    logic [3:0]  in_bn_q, in_bn_d;
    logic        in_s0_q, in_s0_d;
    logic        in_s1_q, in_s1_d;
    logic        in_cin_q, in_cin_d;
    logic        in_fi_q, in_fi_d;

    // ALU output register {cout, d}
    logic [4:0]  res_q, res_d;

    // golden model delay line and valid tracking
    logic [4:0]  gold1_q, gold1_d;
    logic [4:0]  gold2_q, gold2_d;
    logic [1:0]  vld_q, vld_d;

    // analyzer
    logic        err_q, err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // combinational datapath
    logic [3:0]  alu_y;
    logic [3:0]  alu_p;
    logic [3:0]  alu_g;
    logic [4:0]  alu_c;
    logic [3:0]  alu_sum;
    logic [3:0]  gold_y;
    logic [4:0]  gold_res;
    logic        mismatch;

    assign sel = gen_q[2:0];
    assign a   = gen_q[6:3];
    assign b   = gen_q[10:7];

    always_comb begin
        gen_d = gen_q + 11'd1;
    end

    always_comb begin
        in_a_d   = a;
        in_b_d   = b;
        in_bn_d  = ~b;
        in_s0_d  = sel[2];
        in_s1_d  = sel[1];
        in_cin_d = sel[0];
        in_fi_d  = fault_inj;
    end

    always_comb begin
        alu_y = in_b_q;
        case ({in_s0_q, in_s1_q})
            2'b00:   alu_y = in_b_q;
            2'b01:   alu_y = in_bn_q;
            2'b10:   alu_y = 4'b0000;
            default: alu_y = 4'b1111;
        endcase
    end

    // Carries are flattened sum-of-products of P/G so no bit waits on its neighbour.
    always_comb begin
        alu_p    = in_a_q ^ alu_y;
        alu_g    = in_a_q & alu_y;
        alu_c[0] = in_cin_q;
        alu_c[1] = alu_g[0]
                 | (alu_p[0] & in_cin_q);
        alu_c[2] = alu_g[1]
                 | (alu_p[1] & alu_g[0])
                 | (alu_p[1] & alu_p[0] & in_cin_q);
        alu_c[3] = alu_g[2]
                 | (alu_p[2] & alu_g[1])
                 | (alu_p[2] & alu_p[1] & alu_g[0])
                 | (alu_p[2] & alu_p[1] & alu_p[0] & in_cin_q);
        alu_c[4] = alu_g[3]
                 | (alu_p[3] & alu_g[2])
                 | (alu_p[3] & alu_p[2] & alu_g[1])
                 | (alu_p[3] & alu_p[2] & alu_p[1] & alu_g[0])
                 | (alu_p[3] & alu_p[2] & alu_p[1] & alu_p[0] & in_cin_q);
        alu_sum  = alu_p ^ alu_c[3:0];
        res_d    = {alu_c[4], alu_sum ^ {3'b000, in_fi_q}};
    end

    // Golden result is a plain behavioural add, independent of the lookahead tree.
    always_comb begin
        gold_y = b;
        case (sel[2:1])
            2'b00:   gold_y = b;
            2'b01:   gold_y = ~b;
            2'b10:   gold_y = 4'b0000;
            default: gold_y = 4'b1111;
        endcase
        gold_res = {1'b0, a} + {1'b0, gold_y} + {4'b0000, sel[0]};
        gold1_d  = gold_res;
        gold2_d  = gold1_q;
        vld_d    = {vld_q[0], 1'b1};
    end

    always_comb begin
        mismatch  = vld_q[1] & (res_q != gold2_q);
        err_d     = mismatch;
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            gen_q     <= GEN_RST;
            in_a_q    <= 4'b0000;
            in_b_q    <= 4'b0000;
            in_bn_q   <= 4'b0000;
            in_s0_q   <= 1'b0;
            in_s1_q   <= 1'b0;
            in_cin_q  <= 1'b0;
            in_fi_q   <= 1'b0;
            res_q     <= 5'b00000;
            gold1_q   <= 5'b00000;
            gold2_q   <= 5'b00000;
            vld_q     <= 2'b00;
            err_q     <= 1'b0;
            err_cnt_q <= 16'h0000;
        end else begin
            gen_q     <= gen_d;
            in_a_q    <= in_a_d;
            in_b_q    <= in_b_d;
            in_bn_q   <= in_bn_d;
            in_s0_q   <= in_s0_d;
            in_s1_q   <= in_s1_d;
            in_cin_q  <= in_cin_d;
            in_fi_q   <= in_fi_d;
            res_q     <= res_d;
            gold1_q   <= gold1_d;
            gold2_q   <= gold2_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign d         = res_q[3:0];
    assign cout      = res_q[4];
    assign exp_d     = gold2_q[3:0];
    assign exp_cout  = gold2_q[4];
    assign chk_valid = vld_q[1];
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_la_self_test.sv
// Scoreboard bench for alu_la_self_test: expected ALU results are queued as
// each vector is presented and retired two cycles later against d/cout.
module tb_alu_la_self_test;

    localparam logic [10:0] GEN_RST = {4'b0010, 4'b0100, 3'b000};

    typedef struct {
        logic [4:0] res;
        logic [4:0] gold;
    } sb_item_t;

    logic        CLK;
    logic        RST;
    logic        fault_inj;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [2:0]  sel;
    logic [3:0]  d;
    logic        cout;
    logic [3:0]  exp_d;
    logic        exp_cout;
    logic        chk_valid;
    logic        err;
    logic [15:0] err_cnt;

    int          n_chk;
    int          n_fail;
    sb_item_t    sb[$];
    logic [10:0] gen_m;
    int          cyc;
    logic        err_m;
    logic [15:0] cnt_m;
    logic [4:0]  sweep_tbl [8];

    alu_la_self_test dut (
        .CLK       (CLK),
        .RST       (RST),
        .fault_inj (fault_inj),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .d         (d),
        .cout      (cout),
        .exp_d     (exp_d),
        .exp_cout  (exp_cout),
        .chk_valid (chk_valid),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic do_reset(input int n_cyc);
        RST       = 1'b1;
        fault_inj = 1'b0;
        repeat (n_cyc) @(posedge CLK);
        #1;
        check_eq("rst_a", 32'(a), 32'h4);
        check_eq("rst_b", 32'(b), 32'h2);
        check_eq("rst_sel", 32'(sel), 32'h0);
        check_eq("rst_d", 32'(d), 32'h0);
        check_eq("rst_cout", 32'(cout), 32'h0);
        check_eq("rst_exp", 32'({exp_cout, exp_d}), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'h0);
        check_eq("rst_chk_valid", 32'(chk_valid), 32'h0);
        RST = 1'b0;
        sb.delete();
        gen_m = GEN_RST;
        cyc   = 0;
        err_m = 1'b0;
        cnt_m = 16'h0000;
    endtask

    task automatic run_cycle(input logic fi, input bit use_tbl);
        logic [3:0] ma, mb, my;
        logic [2:0] ms;
        logic [4:0] r;
        sb_item_t   it;
        sb_item_t   top;
        ms = gen_m[2:0];
        ma = gen_m[6:3];
        mb = gen_m[10:7];
        fault_inj = fi;
        case (ms[2:1])
            2'b00:   my = mb;
            2'b01:   my = ~mb;
            2'b10:   my = 4'h0;
            default: my = 4'hF;
        endcase
        r       = 5'(ma) + 5'(my) + 5'(ms[0]);
        it.gold = r;
        it.res  = r ^ {4'b0000, fi};
        sb.push_back(it);

        @(negedge CLK);
        check_eq("gen_a", 32'(a), 32'(ma));
        check_eq("gen_b", 32'(b), 32'(mb));
        check_eq("gen_sel", 32'(sel), 32'(ms));
        check_eq("chk_valid", 32'(chk_valid), (cyc >= 2) ? 32'h1 : 32'h0);
        check_eq("err", 32'(err), 32'(err_m));
        check_eq("err_cnt", 32'(err_cnt), 32'(cnt_m));
        if (cyc == 2048) begin
            check_eq("gen_wrap", 32'({b, a, sel}), 32'(GEN_RST));
        end
        if (cyc >= 2) begin
            top = sb.pop_front();
            check_eq("alu_result", 32'({cout, d}), 32'(top.res));
            check_eq("golden", 32'({exp_cout, exp_d}), 32'(top.gold));
            if (use_tbl && cyc <= 9) begin
                check_eq("sel_sweep", 32'({cout, d}), 32'(sweep_tbl[cyc-2]));
            end
            err_m = (top.res != top.gold);
            if (err_m && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end else begin
            err_m = 1'b0;
        end

        @(posedge CLK);
        #1;
        gen_m = gen_m + 11'd1;
        cyc++;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        RST       = 1'b1;
        fault_inj = 1'b0;
        gen_m     = GEN_RST;
        cyc       = 0;
        err_m     = 1'b0;
        cnt_m     = 16'h0000;
        sweep_tbl = '{5'b0_0110, 5'b0_0111, 5'b1_0001, 5'b1_0010,
                      5'b0_0100, 5'b0_0101, 5'b1_0011, 5'b1_0100};

        // reset, first result and sel sweep
        do_reset(2);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b1);

        // fault in cycle 5, second fault in cycle 10 overtaken by reset
        do_reset(2);
        for (int i = 0; i < 12; i++) run_cycle((i == 5) || (i == 10), 1'b0);
        check_eq("err_cnt_before_rst", 32'(err_cnt), 32'h1);
        do_reset(1);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0);

        // full generator period plus pipeline drain
        do_reset(2);
        for (int i = 0; i < 2051; i++) run_cycle(1'b0, 1'b0);
        check_eq("sweep_err_cnt", 32'(err_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
